// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the raster timing generator (video_timing_gen).
package video_timing_pkg;

    localparam int unsigned VT_W = 16;

    typedef enum logic [1:0] {
        SYNC       = 2'd0,
        BACKPORCH  = 2'd1,
        ACTIVE     = 2'd2,
        FRONTPORCH = 2'd3
    } phase_e;

    // Field order matches the {sync,bp,act,fp} packing of cfg_h / cfg_v.
    typedef struct packed {
        logic [VT_W-1:0] sync;
        logic [VT_W-1:0] bp;
        logic [VT_W-1:0] act;
        logic [VT_W-1:0] fp;
    } axis_cfg_t;

    // A zero-length phase behaves as a single pixel/line.
    function automatic logic [31:0] clamp_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: SYNC -> BACKPORCH -> ACTIVE -> FRONTPORCH phase FSM with its counter.
// Back porch counts -bp..-1 so ACTIVE always begins at count 0.
module video_timing_axis
    import video_timing_pkg::*;
#(
    parameter int unsigned W = VT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step_i,
    input  logic [W-1:0] sync_len_i,
    input  logic [W-1:0] bp_len_i,
    input  logic [W-1:0] act_len_i,
    input  logic [W-1:0] fp_len_i,
    output phase_e       phase_o,
    output logic [W-1:0] count_o,
    output logic         last_c
);

    logic [W-1:0] sync_len;
    logic [W-1:0] bp_len;
    logic [W-1:0] act_len;
    logic [W-1:0] fp_len;

    phase_e       phase_q;
    phase_e       phase_d;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         phase_end_c;

    assign sync_len = W'(clamp_len(32'(sync_len_i)));
    assign bp_len   = W'(clamp_len(32'(bp_len_i)));
    assign act_len  = W'(clamp_len(32'(act_len_i)));
    assign fp_len   = W'(clamp_len(32'(fp_len_i)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= SYNC;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        phase_end_c = 1'b0;

        case (phase_q)
            SYNC:       phase_end_c = (cnt_q == sync_len - W'(1));
            BACKPORCH:  phase_end_c = (cnt_q == '1);
            ACTIVE:     phase_end_c = (cnt_q == act_len - W'(1));
            FRONTPORCH: phase_end_c = (cnt_q == fp_len - W'(1));
            default:    phase_end_c = 1'b0;
        endcase

        if (step_i) begin
            if (!phase_end_c) begin
                cnt_d = cnt_q + W'(1);
            end else begin
                cnt_d = '0;
                case (phase_q)
                    SYNC: begin
                        phase_d = BACKPORCH;
                        cnt_d   = W'(0) - bp_len;
                    end
                    BACKPORCH:  phase_d = ACTIVE;
                    ACTIVE:     phase_d = FRONTPORCH;
                    FRONTPORCH: phase_d = SYNC;
                    default:    phase_d = SYNC;
                endcase
            end
        end
    end

    assign phase_o = phase_q;
    assign count_o = cnt_q;
    assign last_c  = (phase_q == FRONTPORCH) && phase_end_c;

endmodule

// File: rtl/video_timing_gen.sv
// Runtime-reprogrammable raster timing generator; mode changes commit only at frame boundaries.
// Optional line-compare interrupt enabled by defining VIDEO_TIMING_LINE_IRQ_EN.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned W      = VT_W,
    parameter int unsigned H_SYNC = 40,
    parameter int unsigned H_BP   = 220,
    parameter int unsigned H_ACT  = 1280,
    parameter int unsigned H_FP   = 110,
    parameter int unsigned V_SYNC = 5,
    parameter int unsigned V_BP   = 20,
    parameter int unsigned V_ACT  = 720,
    parameter int unsigned V_FP   = 5,
    parameter bit          H_POL  = 1'b1,
    parameter bit          V_POL  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*W-1:0]      cfg_h,
    input  logic [4*W-1:0]      cfg_v,
    input  logic [1:0]          cfg_pol,
    input  logic                cfg_load,
    output logic                cfg_pending,
    output logic signed [W-1:0] x,
    output logic signed [W-1:0] y,
    output logic                hsync,
    output logic                vsync,
    output logic                hprep,
    output logic                vprep,
    output logic                visible,
    output logic                line_start,
    output logic                frame_start
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    ,
    input  logic [W-1:0]        cfg_irq_line,
    output logic                line_irq
`endif
);

    localparam logic [4*W-1:0] H_DEF   = {W'(H_SYNC), W'(H_BP), W'(H_ACT), W'(H_FP)};
    localparam logic [4*W-1:0] V_DEF   = {W'(V_SYNC), W'(V_BP), W'(V_ACT), W'(V_FP)};
    localparam logic [1:0]     POL_DEF = {V_POL, H_POL};

    logic [4*W-1:0] shadow_h_q, shadow_h_d;
    logic [4*W-1:0] shadow_v_q, shadow_v_d;
    logic [1:0]     shadow_pol_q, shadow_pol_d;
    logic [4*W-1:0] act_h_q, act_h_d;
    logic [4*W-1:0] act_v_q, act_v_d;
    logic [1:0]     act_pol_q, act_pol_d;
    logic           pending_q, pending_d;

    phase_e         h_phase;
    phase_e         v_phase;
    logic [W-1:0]   h_cnt;
    logic [W-1:0]   v_cnt;
    logic           h_last_c;
    logic           v_last_c;
    logic           frame_end_c;

    logic signed [W-1:0] x_q, x_d;
    logic signed [W-1:0] y_q, y_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic hprep_q, hprep_d;
    logic vprep_q, vprep_d;
    logic visible_q, visible_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    video_timing_axis #(.W(W)) u_h_axis (
        .clk        (clk),
        .reset      (reset),
        .step_i     (1'b1),
        .sync_len_i (act_h_q[4*W-1:3*W]),
        .bp_len_i   (act_h_q[3*W-1:2*W]),
        .act_len_i  (act_h_q[2*W-1:W]),
        .fp_len_i   (act_h_q[W-1:0]),
        .phase_o    (h_phase),
        .count_o    (h_cnt),
        .last_c     (h_last_c)
    );

    video_timing_axis #(.W(W)) u_v_axis (
        .clk        (clk),
        .reset      (reset),
        .step_i     (h_last_c),
        .sync_len_i (act_v_q[4*W-1:3*W]),
        .bp_len_i   (act_v_q[3*W-1:2*W]),
        .act_len_i  (act_v_q[2*W-1:W]),
        .fp_len_i   (act_v_q[W-1:0]),
        .phase_o    (v_phase),
        .count_o    (v_cnt),
        .last_c     (v_last_c)
    );

    assign frame_end_c = h_last_c && v_last_c;

    // Shadow capture and frame-boundary commit; a load on the commit cycle stays pending.
    always_comb begin
        shadow_h_d   = shadow_h_q;
        shadow_v_d   = shadow_v_q;
        shadow_pol_d = shadow_pol_q;
        act_h_d      = act_h_q;
        act_v_d      = act_v_q;
        act_pol_d    = act_pol_q;
        pending_d    = pending_q;

        if (frame_end_c && pending_q) begin
            act_h_d   = shadow_h_q;
            act_v_d   = shadow_v_q;
            act_pol_d = shadow_pol_q;
            pending_d = 1'b0;
        end

        if (cfg_load) begin
            shadow_h_d   = cfg_h;
            shadow_v_d   = cfg_v;
            shadow_pol_d = cfg_pol;
            pending_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_h_q   <= H_DEF;
            shadow_v_q   <= V_DEF;
            shadow_pol_q <= POL_DEF;
            act_h_q      <= H_DEF;
            act_v_q      <= V_DEF;
            act_pol_q    <= POL_DEF;
            pending_q    <= 1'b0;
        end else begin
            shadow_h_q   <= shadow_h_d;
            shadow_v_q   <= shadow_v_d;
            shadow_pol_q <= shadow_pol_d;
            act_h_q      <= act_h_d;
            act_v_q      <= act_v_d;
            act_pol_q    <= act_pol_d;
            pending_q    <= pending_d;
        end
    end

    // Strobe decode; registered so everything lags the axis state by one clock.
    always_comb begin
        x_d           = h_cnt;
        y_d           = v_cnt;
        hsync_d       = (h_phase == SYNC) ~^ act_pol_q[0];
        vsync_d       = (v_phase == SYNC) ~^ act_pol_q[1];
        hprep_d       = (h_phase == BACKPORCH) && (v_phase == ACTIVE);
        vprep_d       = (v_phase == BACKPORCH);
        visible_d     = (h_phase == ACTIVE) && (v_phase == ACTIVE);
        line_start_d  = (h_phase == SYNC) && (h_cnt == '0);
        frame_start_d = line_start_d && (v_phase == SYNC) && (v_cnt == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            hprep_q       <= 1'b0;
            vprep_q       <= 1'b0;
            visible_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hprep_q       <= hprep_d;
            vprep_q       <= vprep_d;
            visible_q     <= visible_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign cfg_pending = pending_q;
    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hprep       = hprep_q;
    assign vprep       = vprep_q;
    assign visible     = visible_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VIDEO_TIMING_LINE_IRQ_EN
    logic line_irq_q, line_irq_d;

    // Live compare; counts beyond the active height never occur in ACTIVE, so they never fire.
    always_comb begin
        line_irq_d = line_start_d && (v_phase == ACTIVE) && (v_cnt == cfg_irq_line);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_irq_q <= 1'b0;
        end else begin
            line_irq_q <= line_irq_d;
        end
    end

    assign line_irq = line_irq_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed self-checking bench for video_timing_gen on a tiny raster mode.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int unsigned W     = 16;
    localparam int unsigned OUT_W = 2*W + 7;

    localparam axis_cfg_t TINY_H = '{16'd2, 16'd3, 16'd8, 16'd2};
    localparam axis_cfg_t TINY_V = '{16'd1, 16'd2, 16'd4, 16'd1};
    localparam axis_cfg_t B_H    = '{16'd1, 16'd1, 16'd4, 16'd1};
    localparam axis_cfg_t B_V    = '{16'd1, 16'd1, 16'd2, 16'd1};
    localparam axis_cfg_t ZFP_H  = '{16'd2, 16'd3, 16'd8, 16'd0};

    // x=0, y=0, hsync=~H_POL=0, vsync=~V_POL=1, all strobes low
    localparam logic [OUT_W-1:0] RST_VEC = {32'd0, 7'b0100000};

    logic                clk = 1'b0;
    logic                reset;
    logic [4*W-1:0]      cfg_h;
    logic [4*W-1:0]      cfg_v;
    logic [1:0]          cfg_pol;
    logic                cfg_load;
    logic                cfg_pending;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic                hsync;
    logic                vsync;
    logic                hprep;
    logic                vprep;
    logic                visible;
    logic                line_start;
    logic                frame_start;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    logic [W-1:0]        cfg_irq_line;
    logic                line_irq;
`endif

    int checks = 0;
    int fails  = 0;

    video_timing_gen #(
        .W(W), .H_SYNC(2), .H_BP(3), .H_ACT(8), .H_FP(2),
        .V_SYNC(1), .V_BP(2), .V_ACT(4), .V_FP(1),
        .H_POL(1'b1), .V_POL(1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_h        (cfg_h),
        .cfg_v        (cfg_v),
        .cfg_pol      (cfg_pol),
        .cfg_load     (cfg_load),
        .cfg_pending  (cfg_pending),
        .x            (x),
        .y            (y),
        .hsync        (hsync),
        .vsync        (vsync),
        .hprep        (hprep),
        .vprep        (vprep),
        .visible      (visible),
        .line_start   (line_start),
        .frame_start  (frame_start)
`ifdef VIDEO_TIMING_LINE_IRQ_EN
        ,
        .cfg_irq_line (cfg_irq_line),
        .line_irq     (line_irq)
`endif
    );

    always #5 clk = ~clk;

    function automatic int cl(input logic [W-1:0] v);
        return int'(clamp_len(32'(v)));
    endfunction

    function automatic int period(input axis_cfg_t c);
        return cl(c.sync) + cl(c.bp) + cl(c.act) + cl(c.fp);
    endfunction

    // Position within an axis period -> phase code and signed count.
    function automatic void axis_pos(input int pos, input axis_cfg_t c,
                                     output logic [1:0] ph, output logic [W-1:0] cnt);
        int s, b, a;
        s = cl(c.sync);
        b = cl(c.bp);
        a = cl(c.act);
        if (pos < s) begin
            ph = 2'd0; cnt = W'(pos);
        end else if (pos < s + b) begin
            ph = 2'd1; cnt = W'(pos - s - b);
        end else if (pos < s + b + a) begin
            ph = 2'd2; cnt = W'(pos - s - b);
        end else begin
            ph = 2'd3; cnt = W'(pos - s - b - a);
        end
    endfunction

    // Expected output vector for output cycle k of a frame (k=0 shows frame_start).
    function automatic logic [OUT_W-1:0] model(input int k, input axis_cfg_t h,
                                               input axis_cfg_t v, input logic [1:0] pol);
        int hp, ln;
        logic [1:0] hph, vph;
        logic [W-1:0] hc, vc;
        hp = k % period(h);
        ln = k / period(h);
        axis_pos(hp, h, hph, hc);
        axis_pos(ln, v, vph, vc);
        return {hc, vc, (hph == 2'd0) ~^ pol[0], (vph == 2'd0) ~^ pol[1],
                (hph == 2'd1) && (vph == 2'd2), vph == 2'd1,
                (hph == 2'd2) && (vph == 2'd2), hp == 0, k == 0};
    endfunction

    function automatic logic [OUT_W-1:0] observed();
        return {x, y, hsync, vsync, hprep, vprep, visible, line_start, frame_start};
    endfunction

    task automatic wait_fs(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        cfg_load = 1'b0;
        cfg_h    = TINY_H;
        cfg_v    = TINY_V;
        cfg_pol  = 2'b01;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
        cfg_irq_line = 16'd2;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (observed() !== RST_VEC) begin
            fails++; $display("FAIL reset_outputs got=%h exp=%h", observed(), RST_VEC);
        end
        checks++;
        if (cfg_pending !== 1'b0) begin
            fails++; $display("FAIL reset_pending got=%b exp=0", cfg_pending);
        end
`ifdef VIDEO_TIMING_LINE_IRQ_EN
        checks++;
        if (line_irq !== 1'b0) begin
            fails++; $display("FAIL reset_line_irq got=%b exp=0", line_irq);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1 || line_start !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b0) begin
            fails++;
            $display("FAIL first_pixel fs=%b ls=%b hs=%b vs=%b exp fs=1 ls=1 hs=1 vs=0",
                     frame_start, line_start, hsync, vsync);
        end
    endtask

    task automatic test_tiny_frame();
        int vis_cnt = 0;
        int ls_cnt  = 0;
        for (int k = 0; k < 120; k++) begin
            checks++;
            if (observed() !== model(k, TINY_H, TINY_V, 2'b01)) begin
                fails++;
                $display("FAIL tiny_frame k=%0d got=%h exp=%h", k, observed(),
                         model(k, TINY_H, TINY_V, 2'b01));
            end
            if (visible === 1'b1) vis_cnt++;
            if (line_start === 1'b1) ls_cnt++;
            @(negedge clk);
        end
        checks++;
        if (frame_start !== 1'b1) begin
            fails++; $display("FAIL tiny_period frame_start at 120 got=%b exp=1", frame_start);
        end
        checks++;
        if (vis_cnt != 32) begin
            fails++; $display("FAIL tiny_visible_count got=%0d exp=32", vis_cnt);
        end
        checks++;
        if (ls_cnt != 8) begin
            fails++; $display("FAIL tiny_line_count got=%0d exp=8", ls_cnt);
        end
    endtask

    task automatic test_bp_seq();
        int xs [11];
        int exp_x [11] = '{-3, -2, -1, 0, 1, 2, 3, 4, 5, 6, 7};
        int hprep_cnt = 0;
        int hprep_bad = 0;
        for (int k = 0; k < 120; k++) begin
            if (k / 15 == 3 && k % 15 >= 2 && k % 15 <= 12) xs[k % 15 - 2] = int'(x);
            if (hprep === 1'b1) begin
                hprep_cnt++;
                if (k / 15 < 3 || k / 15 > 6) hprep_bad++;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (xs[i] != exp_x[i]) begin
                fails++; $display("FAIL bp_x_seq idx=%0d got=%0d exp=%0d", i, xs[i], exp_x[i]);
            end
        end
        checks++;
        if (hprep_cnt != 12 || hprep_bad != 0) begin
            fails++;
            $display("FAIL hprep_lines got count=%0d outside=%0d exp count=12 outside=0",
                     hprep_cnt, hprep_bad);
        end
    endtask

    task automatic test_cfg_commit();
        for (int k = 0; k < 120; k++) begin
            checks++;
            if (observed() !== model(k, TINY_H, TINY_V, 2'b01)) begin
                fails++;
                $display("FAIL commit_old_frame k=%0d got=%h exp=%h", k, observed(),
                         model(k, TINY_H, TINY_V, 2'b01));
            end
            if (k < 30 || (k > 30 && k < 119)) begin
                checks++;
                if (cfg_pending !== (k > 30)) begin
                    fails++; $display("FAIL commit_pending k=%0d got=%b exp=%b", k, cfg_pending, k > 30);
                end
            end
            if (k == 30) begin
                cfg_h = B_H; cfg_v = B_V; cfg_pol = 2'b01; cfg_load = 1'b1;
            end
            if (k == 31) cfg_load = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (cfg_pending !== 1'b0) begin
            fails++; $display("FAIL commit_cleared got=%b exp=0", cfg_pending);
        end
        for (int k = 0; k < 35; k++) begin
            checks++;
            if (observed() !== model(k, B_H, B_V, 2'b01)) begin
                fails++;
                $display("FAIL commit_new_frame k=%0d got=%h exp=%h", k, observed(),
                         model(k, B_H, B_V, 2'b01));
            end
            @(negedge clk);
        end
        checks++;
        if (frame_start !== 1'b1) begin
            fails++; $display("FAIL commit_new_period frame_start at 35 got=%b exp=1", frame_start);
        end
    endtask

    task automatic test_polarity();
        int n;
        int hs_low = 0;
        cfg_h = TINY_H; cfg_v = TINY_V; cfg_pol = 2'b00; cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        wait_fs(100, n);
        checks++;
        if (n != 34) begin
            fails++; $display("FAIL pol_commit_wait got=%0d exp=34", n);
        end
        for (int k = 0; k < 120; k++) begin
            checks++;
            if (observed() !== model(k, TINY_H, TINY_V, 2'b00)) begin
                fails++;
                $display("FAIL pol_frame k=%0d got=%h exp=%h", k, observed(),
                         model(k, TINY_H, TINY_V, 2'b00));
            end
            if (hsync === 1'b0) hs_low++;
            @(negedge clk);
        end
        checks++;
        if (hs_low != 16) begin
            fails++; $display("FAIL pol_hsync_low_count got=%0d exp=16", hs_low);
        end
    endtask

    task automatic test_zero_fp();
        int n;
        cfg_h = ZFP_H; cfg_v = TINY_V; cfg_pol = 2'b01; cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        wait_fs(200, n);
        checks++;
        if (n != 119) begin
            fails++; $display("FAIL zfp_commit_wait got=%0d exp=119", n);
        end
        for (int k = 0; k < 112; k++) begin
            checks++;
            if (observed() !== model(k, ZFP_H, TINY_V, 2'b01)) begin
                fails++;
                $display("FAIL zfp_frame k=%0d got=%h exp=%h", k, observed(),
                         model(k, ZFP_H, TINY_V, 2'b01));
            end
            @(negedge clk);
        end
        checks++;
        if (frame_start !== 1'b1) begin
            fails++; $display("FAIL zfp_period frame_start at 112 got=%b exp=1", frame_start);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        cfg_h = B_H; cfg_v = B_V; cfg_pol = 2'b00; cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        repeat (47) @(negedge clk);
        checks++;
        if (visible !== 1'b1 || cfg_pending !== 1'b1) begin
            fails++; $display("FAIL mid_precond vis=%b pend=%b exp vis=1 pend=1", visible, cfg_pending);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (observed() !== RST_VEC) begin
            fails++; $display("FAIL async_reset_outputs got=%h exp=%h", observed(), RST_VEC);
        end
        checks++;
        if (cfg_pending !== 1'b0) begin
            fails++; $display("FAIL async_reset_pending got=%b exp=0", cfg_pending);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 120; k++) begin
            checks++;
            if (observed() !== model(k, TINY_H, TINY_V, 2'b01)) begin
                fails++;
                $display("FAIL post_reset_frame k=%0d got=%h exp=%h", k, observed(),
                         model(k, TINY_H, TINY_V, 2'b01));
            end
            @(negedge clk);
        end
        checks++;
        if (frame_start !== 1'b1 || cfg_pending !== 1'b0) begin
            fails++; $display("FAIL post_reset_end fs=%b pend=%b exp fs=1 pend=0", frame_start, cfg_pending);
        end
        wait_fs(200, n);
        checks++;
        if (n != 120) begin
            fails++; $display("FAIL post_reset_period got=%0d exp=120", n);
        end
    endtask

`ifdef VIDEO_TIMING_LINE_IRQ_EN
    task automatic test_line_irq();
        int cnt = 0;
        int at_k = -1;
        logic ls_at = 1'b0;
        cfg_irq_line = 16'd2;
        for (int k = 0; k < 120; k++) begin
            if (line_irq === 1'b1) begin
                cnt++; at_k = k; ls_at = line_start;
            end
            @(negedge clk);
        end
        checks++;
        if (cnt != 1 || at_k != 75 || ls_at !== 1'b1) begin
            fails++;
            $display("FAIL irq_line2 got count=%0d k=%0d ls=%b exp count=1 k=75 ls=1", cnt, at_k, ls_at);
        end
        cnt = 0;
        cfg_irq_line = 16'd9;
        for (int k = 0; k < 120; k++) begin
            if (line_irq === 1'b1) cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 0) begin
            fails++; $display("FAIL irq_out_of_range got count=%0d exp=0", cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tiny_frame();
        test_bp_seq();
        test_cfg_commit();
        test_polarity();
        test_zero_fp();
        test_reset_mid();
`ifdef VIDEO_TIMING_LINE_IRQ_EN
        test_line_irq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
